axil_addr_demux: RTL and testbench

- AXI4-Lite 1-to-N address demultiplexer between the core DATA interface's AXI master port and the AXI4-Lite peripherals (UART and later units).
- Decodes each AW/AR address against the system address rules and forwards the transaction to exactly one downstream port.
- Answers unmapped addresses with an internal DECERR responder.
- One outstanding write and one outstanding read at a time. Read and write paths are fully independent.

---
 rtl/axil_pkg.sv | 37 +++
 rtl/soc_addr_rules_pkg.sv | 15 +
 rtl/axil_addr_decode.sv | 31 +++
 rtl/axil_addr_demux.sv | 231 +++++++++++++++++++++++
 tb/tb_axil_addr_demux.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axil_pkg : AXI4-Lite request/response bundles and response codes
// Rev 1.0
// ---------------------------------------------------------------------------
package axil_pkg;

  typedef struct packed {
    logic [31:0] aw_addr;
    logic [2:0]  aw_prot;
    logic        aw_valid;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_valid;
    logic        b_ready;
    logic [31:0] ar_addr;
    logic [2:0]  ar_prot;
    logic        ar_valid;
    logic        r_ready;
  } axil_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        ar_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_valid;
  } axil_resp_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage
`default_nettype wire

// File: rtl/soc_addr_rules_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// soc_addr_rules_pkg : system address-map rule type
// Rev 1.0
// ---------------------------------------------------------------------------
package soc_addr_rules_pkg;

  // One address window; end_addr is exclusive.
  typedef struct packed {
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_rule_t;

endpackage
`default_nettype wire

// File: rtl/axil_addr_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axil_addr_decode : combinational rule matcher, lowest matching index wins
// Rev 1.0
// ---------------------------------------------------------------------------
module axil_addr_decode
  import soc_addr_rules_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 2,
  parameter int unsigned IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic [31:0]                   i_addr,
  input  addr_rule_t [NUM_SLAVES-1:0]   i_rules,
  output logic [IDX_W-1:0]              o_idx,
  output logic                          o_no_match
);

  // Scan from the top down so the lowest matching index is the last written.
  always_comb begin
    o_idx      = '0;
    o_no_match = 1'b1;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((i_addr >= i_rules[i].start_addr) && (i_addr < i_rules[i].end_addr)) begin
        o_idx      = IDX_W'(i);
        o_no_match = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axil_addr_demux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axil_addr_demux : AXI4-Lite 1-to-N address demux with internal DECERR slave
// Rev 1.0
// ---------------------------------------------------------------------------
module axil_addr_demux
  import axil_pkg::*;
  import soc_addr_rules_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 2,
  parameter int unsigned IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  addr_rule_t [NUM_SLAVES-1:0]   addr_rules_i,
  input  axil_req_t                     slv_req_i,
  output axil_resp_t                    slv_resp_o,
  output axil_req_t  [NUM_SLAVES-1:0]   mst_req_o,
  input  axil_resp_t [NUM_SLAVES-1:0]   mst_resp_i
);

  localparam logic [2:0] W_IDLE  = 3'd0;
  localparam logic [2:0] W_DATA  = 3'd1;
  localparam logic [2:0] W_FWD   = 3'd2;
  localparam logic [2:0] W_WAIT  = 3'd3;
  localparam logic [2:0] W_BRESP = 3'd4;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_FWD  = 2'd1;
  localparam logic [1:0] R_WAIT = 2'd2;
  localparam logic [1:0] R_RESP = 2'd3;

  logic [2:0]       r_wstate;
  logic [31:0]      r_aw_addr;
  logic [2:0]       r_aw_prot;
  logic [IDX_W-1:0] r_widx;
  logic             r_werr;
  logic [31:0]      r_w_data;
  logic [3:0]       r_w_strb;
  logic             r_aw_vld;
  logic             r_w_vld;
  logic [1:0]       r_bresp;

  logic [1:0]       r_rstate;
  logic [31:0]      r_ar_addr;
  logic [2:0]       r_ar_prot;
  logic [IDX_W-1:0] r_ridx;
  logic [31:0]      r_rdata;
  logic [1:0]       r_rresp;

  logic [IDX_W-1:0] w_aw_idx;
  logic             w_aw_nomatch;
  logic [IDX_W-1:0] w_ar_idx;
  logic             w_ar_nomatch;

  logic             w_aw_rdy;
  logic             w_w_rdy;
  logic             w_b_vld;
  logic [1:0]       w_b_resp;
  logic             w_ar_rdy;
  logic             w_r_vld;
  logic [31:0]      w_r_data;
  logic [1:0]       w_r_resp;

  axil_addr_decode #(.NUM_SLAVES(NUM_SLAVES), .IDX_W(IDX_W)) u_aw_decode (
    .i_addr     (slv_req_i.aw_addr),
    .i_rules    (addr_rules_i),
    .o_idx      (w_aw_idx),
    .o_no_match (w_aw_nomatch)
  );

  axil_addr_decode #(.NUM_SLAVES(NUM_SLAVES), .IDX_W(IDX_W)) u_ar_decode (
    .i_addr     (slv_req_i.ar_addr),
    .i_rules    (addr_rules_i),
    .o_idx      (w_ar_idx),
    .o_no_match (w_ar_nomatch)
  );

  // Payload is broadcast; only the latched port sees valid/ready, and only its readies are heard.
  always_comb begin
    w_aw_rdy = 1'b0;
    w_w_rdy  = 1'b0;
    w_b_vld  = 1'b0;
    w_b_resp = RESP_OKAY;
    w_ar_rdy = 1'b0;
    w_r_vld  = 1'b0;
    w_r_data = '0;
    w_r_resp = RESP_OKAY;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      mst_req_o[i]         = '0;
      mst_req_o[i].aw_addr = r_aw_addr;
      mst_req_o[i].aw_prot = r_aw_prot;
      mst_req_o[i].w_data  = r_w_data;
      mst_req_o[i].w_strb  = r_w_strb;
      mst_req_o[i].ar_addr = r_ar_addr;
      mst_req_o[i].ar_prot = r_ar_prot;
      if (r_widx == IDX_W'(i)) begin
        mst_req_o[i].aw_valid = r_aw_vld;
        mst_req_o[i].w_valid  = r_w_vld;
        mst_req_o[i].b_ready  = (r_wstate == W_WAIT);
        w_aw_rdy = mst_resp_i[i].aw_ready;
        w_w_rdy  = mst_resp_i[i].w_ready;
        w_b_vld  = mst_resp_i[i].b_valid;
        w_b_resp = mst_resp_i[i].b_resp;
      end
      if (r_ridx == IDX_W'(i)) begin
        mst_req_o[i].ar_valid = (r_rstate == R_FWD);
        mst_req_o[i].r_ready  = (r_rstate == R_WAIT);
        w_ar_rdy = mst_resp_i[i].ar_ready;
        w_r_vld  = mst_resp_i[i].r_valid;
        w_r_data = mst_resp_i[i].r_data;
        w_r_resp = mst_resp_i[i].r_resp;
      end
    end
  end

  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = (r_wstate == W_IDLE);
    slv_resp_o.w_ready  = (r_wstate == W_DATA);
    slv_resp_o.b_valid  = (r_wstate == W_BRESP);
    slv_resp_o.b_resp   = r_bresp;
    slv_resp_o.ar_ready = (r_rstate == R_IDLE);
    slv_resp_o.r_valid  = (r_rstate == R_RESP);
    slv_resp_o.r_data   = r_rdata;
    slv_resp_o.r_resp   = r_rresp;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wstate  <= W_IDLE;
      r_aw_addr <= '0;
      r_aw_prot <= '0;
      r_widx    <= '0;
      r_werr    <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_aw_vld  <= 1'b0;
      r_w_vld   <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (slv_req_i.aw_valid) begin
            r_aw_addr <= slv_req_i.aw_addr;
            r_aw_prot <= slv_req_i.aw_prot;
            r_widx    <= w_aw_idx;
            r_werr    <= w_aw_nomatch;
            r_wstate  <= W_DATA;
          end
        end
        W_DATA: begin
          if (slv_req_i.w_valid) begin
            r_w_data <= slv_req_i.w_data;
            r_w_strb <= slv_req_i.w_strb;
            if (r_werr) begin
              r_bresp  <= RESP_DECERR;
              r_wstate <= W_BRESP;
            end else begin
              r_aw_vld <= 1'b1;
              r_w_vld  <= 1'b1;
              r_wstate <= W_FWD;
            end
          end
        end
        W_FWD: begin
          // AW and W may complete in either order or together.
          if (w_aw_rdy) r_aw_vld <= 1'b0;
          if (w_w_rdy)  r_w_vld  <= 1'b0;
          if ((!r_aw_vld || w_aw_rdy) && (!r_w_vld || w_w_rdy)) begin
            r_wstate <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (w_b_vld) begin
            r_bresp  <= w_b_resp;
            r_wstate <= W_BRESP;
          end
        end
        W_BRESP: begin
          if (slv_req_i.b_ready) r_wstate <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rstate  <= R_IDLE;
      r_ar_addr <= '0;
      r_ar_prot <= '0;
      r_ridx    <= '0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (slv_req_i.ar_valid) begin
            r_ar_addr <= slv_req_i.ar_addr;
            r_ar_prot <= slv_req_i.ar_prot;
            r_ridx    <= w_ar_idx;
            if (w_ar_nomatch) begin
              r_rresp  <= RESP_DECERR;
              r_rdata  <= '0;
              r_rstate <= R_RESP;
            end else begin
              r_rstate <= R_FWD;
            end
          end
        end
        R_FWD: begin
          if (w_ar_rdy) r_rstate <= R_WAIT;
        end
        R_WAIT: begin
          if (w_r_vld) begin
            r_rdata  <= w_r_data;
            r_rresp  <= w_r_resp;
            r_rstate <= R_RESP;
          end
        end
        R_RESP: begin
          if (slv_req_i.r_ready) r_rstate <= R_IDLE;
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axil_addr_demux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axil_addr_demux : directed bench with downstream slave models and a
// per-cycle routing/stability monitor. Rev 1.0
// ---------------------------------------------------------------------------
module tb_axil_addr_demux;
  import axil_pkg::*;
  import soc_addr_rules_pkg::*;

  localparam int NS = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  addr_rule_t [NS-1:0] rules;
  axil_req_t           slv_req;
  axil_resp_t          slv_resp;
  axil_req_t  [NS-1:0] mst_req;
  axil_resp_t [NS-1:0] mst_resp;

  axil_addr_demux #(.NUM_SLAVES(NS)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .addr_rules_i (rules),
    .slv_req_i    (slv_req),
    .slv_resp_o   (slv_resp),
    .mst_req_o    (mst_req),
    .mst_resp_i   (mst_resp)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // upstream master drive
  logic [31:0] up_aw_addr, up_w_data, up_ar_addr;
  logic [3:0]  up_w_strb;
  logic        up_aw_valid, up_w_valid, up_b_ready, up_ar_valid, up_r_ready;

  always_comb begin
    slv_req          = '0;
    slv_req.aw_addr  = up_aw_addr;
    slv_req.aw_prot  = 3'b010;
    slv_req.aw_valid = up_aw_valid;
    slv_req.w_data   = up_w_data;
    slv_req.w_strb   = up_w_strb;
    slv_req.w_valid  = up_w_valid;
    slv_req.b_ready  = up_b_ready;
    slv_req.ar_addr  = up_ar_addr;
    slv_req.ar_prot  = 3'b001;
    slv_req.ar_valid = up_ar_valid;
    slv_req.r_ready  = up_r_ready;
  end

  // downstream slave model state
  logic        ds_bvalid[NS], ds_rvalid[NS];
  logic [31:0] ds_rdata_o[NS], ds_rdata_cfg[NS];
  int          ds_b_delay[NS], ds_r_delay[NS];
  bit          s_aw[NS], s_w[NS], s_b[NS], s_ar[NS], s_r[NS];
  logic [31:0] s_awaddr[NS], s_wdata[NS];
  logic [3:0]  s_wstrb[NS];
  bit          got_aw[NS], got_w[NS], wr_pend[NS], rd_pend[NS];
  int          bcnt[NS], rcnt[NS];
  logic [31:0] last_addr[NS], last_data[NS];
  logic [3:0]  last_strb[NS];
  int          wr_count[NS];

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      mst_resp[i]          = '0;
      mst_resp[i].aw_ready = 1'b1;
      mst_resp[i].w_ready  = 1'b1;
      mst_resp[i].ar_ready = 1'b1;
      mst_resp[i].b_valid  = ds_bvalid[i];
      mst_resp[i].b_resp   = RESP_OKAY;
      mst_resp[i].r_valid  = ds_rvalid[i];
      mst_resp[i].r_data   = ds_rdata_o[i];
      mst_resp[i].r_resp   = RESP_OKAY;
    end
  end

  // expected routing of the transaction currently in flight (-1 = error responder)
  int          exp_wport, exp_rport;
  logic [31:0] exp_waddr, exp_wdata, exp_raddr;
  logic [3:0]  exp_wstrb;

  bit          up_r_hold, up_b_hold;
  logic [31:0] up_r_prev;
  logic [1:0]  up_rresp_prev, up_bresp_prev;

  function automatic void chk_eq(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endfunction

  // Address map semantics: first window (lowest index) containing the address.
  function automatic int exp_port(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if (a >= rules[i].start_addr && a < rules[i].end_addr) return i;
    return -1;
  endfunction

  // Monitor + downstream slaves, one process so sampling and driving are ordered.
  initial begin
    for (int p = 0; p < NS; p++) begin
      ds_bvalid[p] = 0; ds_rvalid[p] = 0; ds_rdata_o[p] = '0;
      got_aw[p] = 0; got_w[p] = 0; wr_pend[p] = 0; rd_pend[p] = 0;
      bcnt[p] = 0; rcnt[p] = 0; wr_count[p] = 0;
      last_addr[p] = '0; last_data[p] = '0; last_strb[p] = '0;
    end
    up_r_hold = 0; up_b_hold = 0; up_r_prev = '0; up_rresp_prev = '0; up_bresp_prev = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int p = 0; p < NS; p++) begin
          if (mst_req[p].aw_valid) begin
            chk_eq("aw route", p, exp_wport);
            chk_eq("aw addr", mst_req[p].aw_addr, exp_waddr);
            chk_eq("aw prot", 32'(mst_req[p].aw_prot), 32'h2);
          end
          if (mst_req[p].w_valid) begin
            chk_eq("w route", p, exp_wport);
            chk_eq("w data", mst_req[p].w_data, exp_wdata);
            chk_eq("w strb", 32'(mst_req[p].w_strb), 32'(exp_wstrb));
          end
          if (mst_req[p].b_ready) chk_eq("bready route", p, exp_wport);
          if (mst_req[p].ar_valid) begin
            chk_eq("ar route", p, exp_rport);
            chk_eq("ar addr", mst_req[p].ar_addr, exp_raddr);
            chk_eq("ar prot", 32'(mst_req[p].ar_prot), 32'h1);
          end
          if (mst_req[p].r_ready) chk_eq("rready route", p, exp_rport);
        end
        if (up_r_hold) begin
          chk_eq("r valid stable", 32'(slv_resp.r_valid), 32'h1);
          chk_eq("r data stable", slv_resp.r_data, up_r_prev);
          chk_eq("r resp stable", 32'(slv_resp.r_resp), 32'(up_rresp_prev));
        end
        if (up_b_hold) begin
          chk_eq("b valid stable", 32'(slv_resp.b_valid), 32'h1);
          chk_eq("b resp stable", 32'(slv_resp.b_resp), 32'(up_bresp_prev));
        end
        up_r_hold = slv_resp.r_valid && !up_r_ready;
        up_r_prev = slv_resp.r_data;
        up_rresp_prev = slv_resp.r_resp;
        up_b_hold = slv_resp.b_valid && !up_b_ready;
        up_bresp_prev = slv_resp.b_resp;
      end else begin
        up_r_hold = 0;
        up_b_hold = 0;
      end
      for (int p = 0; p < NS; p++) begin
        s_aw[p] = mst_req[p].aw_valid; s_awaddr[p] = mst_req[p].aw_addr;
        s_w[p] = mst_req[p].w_valid; s_wdata[p] = mst_req[p].w_data; s_wstrb[p] = mst_req[p].w_strb;
        s_b[p] = ds_bvalid[p] && mst_req[p].b_ready;
        s_ar[p] = mst_req[p].ar_valid;
        s_r[p] = ds_rvalid[p] && mst_req[p].r_ready;
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < NS; p++) begin
        if (!rst_n) begin
          ds_bvalid[p] = 0; ds_rvalid[p] = 0;
          got_aw[p] = 0; got_w[p] = 0; wr_pend[p] = 0; rd_pend[p] = 0;
        end else begin
          if (s_aw[p]) begin got_aw[p] = 1; last_addr[p] = s_awaddr[p]; end
          if (s_w[p]) begin got_w[p] = 1; last_data[p] = s_wdata[p]; last_strb[p] = s_wstrb[p]; end
          if (s_b[p]) ds_bvalid[p] = 0;
          if (s_r[p]) ds_rvalid[p] = 0;
          if (got_aw[p] && got_w[p]) begin
            got_aw[p] = 0; got_w[p] = 0; wr_count[p]++;
            wr_pend[p] = 1; bcnt[p] = ds_b_delay[p];
          end
          if (wr_pend[p]) begin
            if (bcnt[p] == 0) begin ds_bvalid[p] = 1; wr_pend[p] = 0; end
            else bcnt[p]--;
          end
          if (s_ar[p]) begin rd_pend[p] = 1; rcnt[p] = ds_r_delay[p]; end
          if (rd_pend[p]) begin
            if (rcnt[p] == 0) begin ds_rvalid[p] = 1; ds_rdata_o[p] = ds_rdata_cfg[p]; rd_pend[p] = 0; end
            else rcnt[p]--;
          end
        end
      end
    end
  end

  // st: 0 seen, 1 timed out (counted as failure), 2 reset intervened
  task automatic wait_sig(input int which, input string nm, output int st);
    st = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!rst_n) begin st = 2; return; end
      case (which)
        0: if (slv_resp.aw_ready) return;
        1: if (slv_resp.w_ready)  return;
        2: if (slv_resp.b_valid)  return;
        3: if (slv_resp.ar_ready) return;
        default: if (slv_resp.r_valid) return;
      endcase
    end
    st = 1;
    n_tests++;
    n_fail++;
    $display("FAIL timeout %s: got no handshake, want one within 60 cycles", nm);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int st);
    resp = 2'b01;
    exp_wport = exp_port(a); exp_waddr = a; exp_wdata = d; exp_wstrb = s;
    @(posedge clk); #1;
    up_aw_addr = a; up_aw_valid = 1;
    wait_sig(0, "aw", st);
    if (st != 0) begin up_aw_valid = 0; return; end
    @(posedge clk); #1;
    up_aw_valid = 0; up_w_data = d; up_w_strb = s; up_w_valid = 1;
    wait_sig(1, "w", st);
    if (st != 0) begin up_w_valid = 0; return; end
    @(posedge clk); #1;
    up_w_valid = 0; up_b_ready = 1;
    wait_sig(2, "b", st);
    if (st != 0) begin up_b_ready = 0; return; end
    resp = slv_resp.b_resp;
    @(posedge clk); #1;
    up_b_ready = 0;
  endtask

  task automatic do_read(input logic [31:0] a, input int hold,
                         output logic [31:0] data, output logic [1:0] resp, output int st);
    data = 32'hFFFF_FFFF; resp = 2'b01;
    exp_rport = exp_port(a); exp_raddr = a;
    @(posedge clk); #1;
    up_ar_addr = a; up_ar_valid = 1;
    wait_sig(3, "ar", st);
    if (st != 0) begin up_ar_valid = 0; return; end
    @(posedge clk); #1;
    up_ar_valid = 0; up_r_ready = (hold == 0);
    wait_sig(4, "r", st);
    if (st != 0) begin up_r_ready = 0; return; end
    data = slv_resp.r_data;
    resp = slv_resp.r_resp;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk_eq("hold rvalid", 32'(slv_resp.r_valid), 32'h1);
      chk_eq("hold rdata", slv_resp.r_data, data);
      chk_eq("hold arready", 32'(slv_resp.ar_ready), 32'h0);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      up_r_ready = 1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    up_r_ready = 0;
  endtask

  task automatic check_write(input string nm, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] resp, input int st,
                             input int b0, input int b1);
    int p;
    p = exp_port(a);
    chk_eq({nm, " status"}, st, 0);
    if (p < 0) begin
      chk_eq({nm, " bresp"}, 32'(resp), 32'(RESP_DECERR));
      chk_eq({nm, " no ds write"}, wr_count[0] + wr_count[1], b0 + b1);
    end else begin
      chk_eq({nm, " bresp"}, 32'(resp), 32'(RESP_OKAY));
      chk_eq({nm, " ds count"}, wr_count[p], ((p == 0) ? b0 : b1) + 1);
      chk_eq({nm, " ds addr"}, last_addr[p], a);
      chk_eq({nm, " ds data"}, last_data[p], d);
      chk_eq({nm, " ds strb"}, 32'(last_strb[p]), 32'(s));
    end
  endtask

  task automatic check_read(input string nm, input logic [31:0] a, input logic [31:0] data,
                            input logic [1:0] resp, input int st);
    int p;
    p = exp_port(a);
    chk_eq({nm, " status"}, st, 0);
    chk_eq({nm, " rresp"}, 32'(resp), (p < 0) ? 32'(RESP_DECERR) : 32'(RESP_OKAY));
    chk_eq({nm, " rdata"}, data, (p < 0) ? 32'h0 : ds_rdata_cfg[p]);
  endtask

  task automatic check_reset(input string nm);
    logic [4:0] v;
    chk_eq({nm, " awready"}, 32'(slv_resp.aw_ready), 32'h1);
    chk_eq({nm, " arready"}, 32'(slv_resp.ar_ready), 32'h1);
    chk_eq({nm, " wready"},  32'(slv_resp.w_ready),  32'h0);
    chk_eq({nm, " bvalid"},  32'(slv_resp.b_valid),  32'h0);
    chk_eq({nm, " rvalid"},  32'(slv_resp.r_valid),  32'h0);
    chk_eq({nm, " rdata"},   slv_resp.r_data,        32'h0);
    for (int p = 0; p < NS; p++) begin
      v = {mst_req[p].aw_valid, mst_req[p].w_valid, mst_req[p].b_ready,
           mst_req[p].ar_valid, mst_req[p].r_ready};
      chk_eq({nm, " ds valids"}, 32'(v), 32'h0);
      chk_eq({nm, " ds awaddr"}, mst_req[p].aw_addr, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp, resp2;
    logic [31:0] data;
    int          st, st2, b0, b1, found;

    rst_n = 0;
    up_aw_addr = '0; up_w_data = '0; up_ar_addr = '0; up_w_strb = '0;
    up_aw_valid = 0; up_w_valid = 0; up_b_ready = 0; up_ar_valid = 0; up_r_ready = 0;
    rules[0] = '{start_addr: 32'h0001_0000, end_addr: 32'h0001_0030};
    rules[1] = '{start_addr: 32'h0002_0000, end_addr: 32'h0002_1000};
    ds_rdata_cfg[0] = 32'hA5A5_0000; ds_rdata_cfg[1] = 32'h1234_5678;
    ds_b_delay[0] = 0; ds_b_delay[1] = 0; ds_r_delay[0] = 0; ds_r_delay[1] = 0;
    exp_wport = -1; exp_rport = -1;
    exp_waddr = '0; exp_wdata = '0; exp_wstrb = '0; exp_raddr = '0;

    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1;

    // write to port0
    b0 = wr_count[0]; b1 = wr_count[1];
    do_write(32'h0001_0004, 32'h0000_0055, 4'hF, resp, st);
    chk_eq("T1 bresp literal", 32'(resp), 32'h0);
    chk_eq("T1 p0 data literal", last_data[0], 32'h0000_0055);
    check_write("T1", 32'h0001_0004, 32'h0000_0055, 4'hF, resp, st, b0, b1);

    // read port1 with 3 wait cycles
    ds_r_delay[1] = 3;
    do_read(32'h0002_0010, 0, data, resp, st);
    chk_eq("T2 rdata literal", data, 32'h1234_5678);
    chk_eq("T2 rresp literal", 32'(resp), 32'h0);
    check_read("T2", 32'h0002_0010, data, resp, st);

    // exclusive end of rule 0
    do_read(32'h0001_0030, 0, data, resp, st);
    chk_eq("T3 rresp literal", 32'(resp), 32'h3);
    chk_eq("T3 rdata literal", data, 32'h0);
    check_read("T3", 32'h0001_0030, data, resp, st);

    // unmapped write
    b0 = wr_count[0]; b1 = wr_count[1];
    do_write(32'h3000_0000, 32'h1111_2222, 4'hF, resp, st);
    chk_eq("T4 bresp literal", 32'(resp), 32'h3);
    check_write("T4", 32'h3000_0000, 32'h1111_2222, 4'hF, resp, st, b0, b1);

    // read held in response phase with a concurrent write to port0
    b0 = wr_count[0]; b1 = wr_count[1];
    fork
      do_read(32'h0002_0020, 5, data, resp2, st2);
      do_write(32'h0001_0010, 32'h0000_00AA, 4'h3, resp, st);
    join
    check_read("T5 rd", 32'h0002_0020, data, resp2, st2);
    check_write("T5 wr", 32'h0001_0010, 32'h0000_00AA, 4'h3, resp, st, b0, b1);

    // boundaries
    b0 = wr_count[0]; b1 = wr_count[1];
    do_write(32'h0002_0FFC, 32'hCAFE_F00D, 4'hC, resp, st);
    check_write("T6 last", 32'h0002_0FFC, 32'hCAFE_F00D, 4'hC, resp, st, b0, b1);
    do_read(32'h0001_0000, 0, data, resp, st);
    chk_eq("T6 start rdata literal", data, 32'hA5A5_0000);
    check_read("T6 start", 32'h0001_0000, data, resp, st);
    b0 = wr_count[0]; b1 = wr_count[1];
    do_write(32'h0002_1000, 32'h0BAD_0BAD, 4'hF, resp, st);
    check_write("T6 end", 32'h0002_1000, 32'h0BAD_0BAD, 4'hF, resp, st, b0, b1);

    // overlapping rules: lowest index wins
    rules[1] = '{start_addr: 32'h0000_0000, end_addr: 32'hFFFF_FFFF};
    do_read(32'h0001_0004, 0, data, resp, st);
    chk_eq("T7 overlap rdata literal", data, 32'hA5A5_0000);
    check_read("T7 overlap", 32'h0001_0004, data, resp, st);
    do_read(32'h0005_0000, 0, data, resp, st);
    chk_eq("T7 wide rdata literal", data, 32'h1234_5678);
    check_read("T7 wide", 32'h0005_0000, data, resp, st);
    rules[1] = '{start_addr: 32'h0002_0000, end_addr: 32'h0002_1000};

    // reset while waiting for downstream B
    ds_b_delay[0] = 30;
    fork
      begin
        do_write(32'h0001_0008, 32'hDEAD_BEEF, 4'hF, resp, st);
        chk_eq("T8 aborted", st, 2);
      end
      begin
        found = 0;
        for (int k = 0; k < 60 && found == 0; k++) begin
          @(negedge clk);
          if (mst_req[0].b_ready) found = 1;
        end
        chk_eq("T8 reached W_WAIT", found, 1);
        rst_n = 0;
        @(posedge clk); #1;
        check_reset("T8 mid reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
      end
    join
    ds_b_delay[0] = 0;
    exp_wport = -1;
    @(negedge clk);
    chk_eq("T8 awready after", 32'(slv_resp.aw_ready), 32'h1);
    b0 = wr_count[0]; b1 = wr_count[1];
    do_write(32'h0001_000C, 32'h7777_8888, 4'h5, resp, st);
    check_write("T8 fresh", 32'h0001_000C, 32'h7777_8888, 4'h5, resp, st, b0, b1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
